// File: rtl/step_counter_rate_pkg.sv
// step_counter_rate_pkg: mode encoding and default parameters shared by the counter slice
package step_counter_rate_pkg;
    localparam int WIDTH_DEF       = 8;
    localparam int DELTA_W_DEF     = 4;
    localparam int FREQ_W_DEF      = 40;
    localparam int GATE_CYCLES_DEF = 1000;
    typedef enum logic {MODE_WRAP = 1'b0, MODE_SAT = 1'b1} mode_e;
endpackage

// File: rtl/step_counter_rate_if.sv
// step_counter_rate_if: control inputs and status outputs of the step counter
interface step_counter_rate_if
    import step_counter_rate_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int DELTA_W = DELTA_W_DEF,
    parameter int FREQ_W  = FREQ_W_DEF
);
    logic               en;
    logic               preload;
    logic               up_dn;
    logic               mode;
    logic [DELTA_W-1:0] delta;
    logic [WIDTH-1:0]   pl_data;
    logic [WIDTH-1:0]   qout;
    logic               wrap_pulse;
    logic               sat_flag;
    logic [FREQ_W-1:0]  freq_out;
    logic               freq_valid;
    modport master (
        output en, preload, up_dn, mode, delta, pl_data,
        input  qout, wrap_pulse, sat_flag, freq_out, freq_valid
    );
    modport slave (
        input  en, preload, up_dn, mode, delta, pl_data,
        output qout, wrap_pulse, sat_flag, freq_out, freq_valid
    );
endinterface

// File: rtl/step_counter_rate_rate_meter.sv
// step_counter_rate_rate_meter: counts event pulses over a free-running gate window
module step_counter_rate_rate_meter
    import step_counter_rate_pkg::*;
#(
    parameter int GATE_CYCLES = GATE_CYCLES_DEF,
    parameter int FREQ_W      = FREQ_W_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              event_i,
    output logic [FREQ_W-1:0] freq_o,
    output logic              valid_o
);
    localparam int GATE_W = $clog2(GATE_CYCLES);
    logic [GATE_W-1:0] gate_q;
    logic [FREQ_W-1:0] evt_q, evt_d;
    logic              last;
    assign last  = gate_q == GATE_W'(GATE_CYCLES - 1);
    // the closing cycle's own event is folded into the reported tally
    assign evt_d = (event_i && !(&evt_q)) ? evt_q + FREQ_W'(1) : evt_q;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gate_q  <= '0;
            evt_q   <= '0;
            freq_o  <= '0;
            valid_o <= 1'b0;
        end else begin
            gate_q  <= last ? '0 : gate_q + GATE_W'(1);
            evt_q   <= last ? '0 : evt_d;
            freq_o  <= last ? evt_d : freq_o;
            valid_o <= last;
        end
    end
endmodule

// File: rtl/step_counter_rate.sv
// step_counter_rate: up/down step counter with preload, wrap/saturate modes and a wrap-rate meter
module step_counter_rate
    import step_counter_rate_pkg::*;
#(
    parameter int WIDTH       = WIDTH_DEF,
    parameter int DELTA_W     = DELTA_W_DEF,
    parameter int FREQ_W      = FREQ_W_DEF,
    parameter int GATE_CYCLES = GATE_CYCLES_DEF
) (
    input logic               clk,
    input logic               reset_n,
    step_counter_rate_if.slave bus
);
    logic [WIDTH-1:0] qout_q, qout_d;
    logic             wrap_q, wrap_d;
    logic             sat_q, sat_d;
    logic [WIDTH:0]   dext, sum;
    logic             step, ovf, clamp;
    assign dext  = {{(WIDTH + 1 - DELTA_W){1'b0}}, bus.delta};
    assign sum   = bus.up_dn ? {1'b0, qout_q} + dext : {1'b0, qout_q} - dext;
    assign step  = !bus.preload && bus.en && (bus.delta != '0);
    // bit WIDTH of the extended sum is the carry going up and the borrow going down
    assign ovf   = sum[WIDTH];
    assign clamp = ovf && (bus.mode == MODE_SAT);
    always_comb begin
        qout_d = bus.preload ? bus.pl_data
               : !step       ? qout_q
               : clamp       ? (bus.up_dn ? '1 : '0)
               :               sum[WIDTH-1:0];
        wrap_d = step && ovf && !clamp;
        sat_d  = bus.preload ? 1'b0 : step ? clamp : sat_q;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            qout_q <= '0;
            wrap_q <= 1'b0;
            sat_q  <= 1'b0;
        end else begin
            qout_q <= qout_d;
            wrap_q <= wrap_d;
            sat_q  <= sat_d;
        end
    end
    assign bus.qout       = qout_q;
    assign bus.wrap_pulse = wrap_q;
    assign bus.sat_flag   = sat_q;
    step_counter_rate_rate_meter #(
        .GATE_CYCLES(GATE_CYCLES),
        .FREQ_W     (FREQ_W)
    ) u_rate_meter (
        .clk    (clk),
        .reset_n(reset_n),
        .event_i(wrap_d),
        .freq_o (bus.freq_out),
        .valid_o(bus.freq_valid)
    );
endmodule
